id_ex_stage: RTL and testbench

//  ID/EX pipeline stage, directly downstream of the control decoder. Registers decoded control
//  (ALUop, RegWrite, branch), operands and destination register into EX. Detects load-use hazards
//  and inserts bubbles. Squashes the ID instruction on a taken branch or jump resolved in EX.

---
 rtl/id_ex_stage_pkg.sv | 54 +++++
 rtl/id_ex_stage_hazard_detect.sv | 59 +++++
 rtl/id_ex_stage.sv | 187 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared decode constants for the ID/EX stage. The opcode/func values and the
// ALUop encodings are the same ones the upstream control decoder uses, so the
// two blocks always agree on what an instruction is.
// Also holds small classification helpers used by the hazard logic.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    // Primary opcodes (instruction [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h03;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h07;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h12;
    localparam logic [5:0] OP_LBU   = 6'h22;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction [5:0])
    localparam logic [5:0] FN_LWN   = 6'h21;

    // ALU operation encodings produced by the control decoder
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_LUI  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_NOR  = 3'd7
    } alu_op_e;

    // Instructions that read rt as a source operand (R-type ALU, branches, stores)
    function automatic logic op_uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
               (opcode == OP_SB)    || (opcode == OP_SW);
    endfunction

    // Everything reads rs except jumps and lui, whose rs field is not a register
    function automatic logic op_uses_rs(input logic [5:0] opcode);
        return !((opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_LUI));
    endfunction

    // Loads: lw, lbu, and the R-type indexed load lwn
    function automatic logic op_is_load(input logic [5:0] opcode, input logic [5:0] func);
        return (opcode == OP_LW) || (opcode == OP_LBU) ||
               ((opcode == OP_RTYPE) && (func == FN_LWN));
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// id_ex_stage_hazard_detect  (the hazard_detect block of id_ex_stage)
// Purely combinational. Classifies the ID instruction (source usage, load,
// destination register) and flags a load-use hazard against the instruction
// currently in EX.
// Ports:
//   id_valid, id_opcode, id_func, id_rs, id_rt, id_rd : ID instruction fields
//   ex_valid, ex_is_load, ex_RegWrite, ex_wreg        : current EX state
//   is_load  : ID instruction is a load
//   wreg     : ID destination index (rd / LINK_REG / rt)
//   hazard   : EX load writes a register the ID instruction reads
// ---------------------------------------------------------------------------
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_func,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_RegWrite,
    input  logic [REG_AW-1:0] ex_wreg,
    output logic              is_load,
    output logic [REG_AW-1:0] wreg,
    output logic              hazard
);

    logic uses_rs;
    logic uses_rt;
    logic rs_match;
    logic rt_match;
    logic ex_load_writes;

    assign uses_rs = op_uses_rs(id_opcode);
    assign uses_rt = op_uses_rt(id_opcode);
    assign is_load = op_is_load(id_opcode, id_func);

    always_comb begin
        wreg = id_rt;
        if (id_opcode == OP_RTYPE) begin
            wreg = id_rd;
        end else if (id_opcode == OP_JAL) begin
            wreg = REG_AW'(LINK_REG);
        end
    end

    // r0 is hardwired, so a load targeting it can never create a dependency.
    assign ex_load_writes = ex_valid && ex_is_load && ex_RegWrite && (ex_wreg != '0);
    assign rs_match       = uses_rs && (id_rs == ex_wreg);
    assign rt_match       = uses_rt && (id_rt == ex_wreg);
    assign hazard         = ex_load_writes && id_valid && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register. Captures decoded control, operands and the
// destination index into EX one cycle after ID, inserts a bubble on a
// load-use hazard (asserting stall to freeze PC and IF/ID for one cycle),
// and squashes the ID instruction when EX resolves a taken branch/jump.
// Saturating stall/flush cycle counters support performance debug.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   id_*                          : ID instruction, decoded control, operands
//   ex_flush                      : taken branch/jump resolved in EX
//   stall                         : combinational hold request for PC, IF/ID
//   ex_*                          : registered EX contents
//   stall_cnt, flush_cnt          : saturating event counters
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 16,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_func,
    input  logic [2:0]        id_ALUop,
    input  logic              id_RegWrite,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [2:0]        ex_ALUop,
    output logic              ex_RegWrite,
    output logic              ex_branch,
    output logic              ex_is_load,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_AW-1:0] ex_wreg,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // EX state
    logic              valid_reg,    valid_next;
    logic [2:0]        alu_op_reg,   alu_op_next;
    logic              reg_write_reg, reg_write_next;
    logic              branch_reg,   branch_next;
    logic              is_load_reg,  is_load_next;
    logic [DATA_W-1:0] rs_data_reg,  rs_data_next;
    logic [DATA_W-1:0] rt_data_reg,  rt_data_next;
    logic [DATA_W-1:0] imm_reg,      imm_next;
    logic [DATA_W-1:0] pc_reg,       pc_next;
    logic [REG_AW-1:0] wreg_reg,     wreg_next;

    logic              id_is_load;
    logic [REG_AW-1:0] id_wreg;
    logic              hazard;
    logic              bubble;

    id_ex_stage_hazard_detect #(
        .REG_AW   (REG_AW),
        .LINK_REG (LINK_REG)
    ) u_hazard_detect (
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_func     (id_func),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .ex_valid    (valid_reg),
        .ex_is_load  (is_load_reg),
        .ex_RegWrite (reg_write_reg),
        .ex_wreg     (wreg_reg),
        .is_load     (id_is_load),
        .wreg        (id_wreg),
        .hazard      (hazard)
    );

    // A flush squashes the ID instruction anyway, so there is nothing to hold.
    // Gating with rst keeps stall low for the whole reset window.
    assign stall  = hazard && !ex_flush && !rst;
    assign bubble = ex_flush || stall;

    always_comb begin
        // Data fields hold by default; a bubble only clears the control bits.
        valid_next     = valid_reg;
        alu_op_next    = alu_op_reg;
        reg_write_next = reg_write_reg;
        branch_next    = branch_reg;
        is_load_next   = is_load_reg;
        rs_data_next   = rs_data_reg;
        rt_data_next   = rt_data_reg;
        imm_next       = imm_reg;
        pc_next        = pc_reg;
        wreg_next      = wreg_reg;

        if (bubble) begin
            valid_next     = 1'b0;
            reg_write_next = 1'b0;
            branch_next    = 1'b0;
            is_load_next   = 1'b0;
        end else begin
            // An empty ID slot still moves through, but must not cause side effects.
            valid_next     = id_valid;
            alu_op_next    = id_ALUop;
            reg_write_next = id_RegWrite && id_valid;
            branch_next    = id_branch && id_valid;
            is_load_next   = id_is_load && id_valid;
            rs_data_next   = id_rs_data;
            rt_data_next   = id_rt_data;
            imm_next       = id_imm;
            pc_next        = id_pc;
            wreg_next      = id_wreg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            alu_op_reg    <= '0;
            reg_write_reg <= 1'b0;
            branch_reg    <= 1'b0;
            is_load_reg   <= 1'b0;
            rs_data_reg   <= '0;
            rt_data_reg   <= '0;
            imm_reg       <= '0;
            pc_reg        <= '0;
            wreg_reg      <= '0;
        end else begin
            valid_reg     <= valid_next;
            alu_op_reg    <= alu_op_next;
            reg_write_reg <= reg_write_next;
            branch_reg    <= branch_next;
            is_load_reg   <= is_load_next;
            rs_data_reg   <= rs_data_next;
            rt_data_reg   <= rt_data_next;
            imm_reg       <= imm_next;
            pc_reg        <= pc_next;
            wreg_reg      <= wreg_next;
        end
    end

    assign ex_valid    = valid_reg;
    assign ex_ALUop    = alu_op_reg;
    assign ex_RegWrite = reg_write_reg;
    assign ex_branch   = branch_reg;
    assign ex_is_load  = is_load_reg;
    assign ex_rs_data  = rs_data_reg;
    assign ex_rt_data  = rt_data_reg;
    assign ex_imm      = imm_reg;
    assign ex_pc       = pc_reg;
    assign ex_wreg     = wreg_reg;

    // Saturating performance counters: index 0 counts stalls, 1 counts flushes.
    logic [1:0] cnt_evt;
    assign cnt_evt = {ex_flush, stall};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_evt[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_cnt = g_cnt[0].cnt_reg;
    assign flush_cnt = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed vectors with hand-computed expectations. The driver applies one ID
// instruction per cycle on the falling edge and pushes the expected stall and
// the expected EX contents into queues; two monitor processes pop and compare
// (stall just after the falling edge, EX contents just after the rising edge).
// Counters are built narrow (CNT_W=2) so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [5:0]        id_opcode;
    logic [5:0]        id_func;
    logic [2:0]        id_ALUop;
    logic              id_RegWrite;
    logic              id_branch;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc;
    logic              ex_flush;
    logic              stall;
    logic              ex_valid;
    logic [2:0]        ex_ALUop;
    logic              ex_RegWrite;
    logic              ex_branch;
    logic              ex_is_load;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
    logic [REG_AW-1:0] ex_wreg;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    id_ex_stage #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .CNT_W    (CNT_W),
        .LINK_REG (31)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_func     (id_func),
        .id_ALUop    (id_ALUop),
        .id_RegWrite (id_RegWrite),
        .id_branch   (id_branch),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_rs_data  (id_rs_data),
        .id_rt_data  (id_rt_data),
        .id_imm      (id_imm),
        .id_pc       (id_pc),
        .ex_flush    (ex_flush),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_ALUop    (ex_ALUop),
        .ex_RegWrite (ex_RegWrite),
        .ex_branch   (ex_branch),
        .ex_is_load  (ex_is_load),
        .ex_rs_data  (ex_rs_data),
        .ex_rt_data  (ex_rt_data),
        .ex_imm      (ex_imm),
        .ex_pc       (ex_pc),
        .ex_wreg     (ex_wreg),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        valid;
        logic        rw;
        logic        br;
        logic        ld;
        logic [4:0]  wreg;
        logic [2:0]  alu;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [1:0]  sc;
        logic [1:0]  fc;
    } exp_t;

    exp_t stall_q[$];
    exp_t ex_q[$];

    int n_cmp = 0;
    int n_mis = 0;
    int seq   = 0;
    logic [1:0] sc_exp = 2'd0;
    logic [1:0] fc_exp = 2'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Apply one ID instruction; operand data is derived from a running sequence number.
    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [2:0] alu, input logic rw, input logic br,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic fl);
        seq++;
        id_valid    = v;
        id_opcode   = op;
        id_func     = fn;
        id_ALUop    = alu;
        id_RegWrite = rw;
        id_branch   = br;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_rs_data  = 32'hA000_0000 + seq;
        id_rt_data  = 32'hB000_0000 + seq;
        id_imm      = 32'hC000_0000 + seq;
        id_pc       = 32'h0040_0000 + 32'(seq * 4);
        ex_flush    = fl;
    endtask

    task automatic issue(input string nm,
                         input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [2:0] alu, input logic rw, input logic br,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic fl,
                         input logic e_stall, input logic e_valid, input logic e_rw,
                         input logic e_br, input logic e_ld, input logic [4:0] e_wreg);
        exp_t e;
        @(negedge clk);
        drive(v, op, fn, alu, rw, br, rs, rt, rd, fl);
        if (fl && fc_exp != 2'd3) fc_exp++;
        if (e_stall && sc_exp != 2'd3) sc_exp++;
        e.name  = nm;
        e.stall = e_stall;
        e.valid = e_valid;
        e.rw    = e_rw;
        e.br    = e_br;
        e.ld    = e_ld;
        e.wreg  = e_wreg;
        e.alu   = alu;
        e.rs_d  = 32'hA000_0000 + seq;
        e.rt_d  = 32'hB000_0000 + seq;
        e.imm   = 32'hC000_0000 + seq;
        e.pc    = 32'h0040_0000 + 32'(seq * 4);
        e.sc    = sc_exp;
        e.fc    = fc_exp;
        stall_q.push_back(e);
        ex_q.push_back(e);
    endtask

    // Stall monitor: combinational output, sampled mid-low-phase.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (stall_q.size() > 0) begin
                exp_t e;
                e = stall_q.pop_front();
                chk({e.name, ".stall"}, 32'(stall), 32'(e.stall));
            end
        end
    end

    // EX monitor: registered outputs, sampled just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ex_q.size() > 0) begin
                exp_t e;
                e = ex_q.pop_front();
                chk({e.name, ".ex_valid"},    32'(ex_valid),    32'(e.valid));
                chk({e.name, ".ex_RegWrite"}, 32'(ex_RegWrite), 32'(e.rw));
                chk({e.name, ".ex_branch"},   32'(ex_branch),   32'(e.br));
                chk({e.name, ".ex_is_load"},  32'(ex_is_load),  32'(e.ld));
                chk({e.name, ".stall_cnt"},   32'(stall_cnt),   32'(e.sc));
                chk({e.name, ".flush_cnt"},   32'(flush_cnt),   32'(e.fc));
                if (e.valid) begin
                    chk({e.name, ".ex_wreg"},    32'(ex_wreg),  32'(e.wreg));
                    chk({e.name, ".ex_ALUop"},   32'(ex_ALUop), 32'(e.alu));
                    chk({e.name, ".ex_rs_data"}, ex_rs_data,    e.rs_d);
                    chk({e.name, ".ex_rt_data"}, ex_rt_data,    e.rt_d);
                    chk({e.name, ".ex_imm"},     ex_imm,        e.imm);
                    chk({e.name, ".ex_pc"},      ex_pc,         e.pc);
                end
                $display("txn %-10s valid=%0b rw=%0b br=%0b ld=%0b wreg=%0d scnt=%0d fcnt=%0d",
                         e.name, ex_valid, ex_RegWrite, ex_branch, ex_is_load, ex_wreg,
                         stall_cnt, flush_cnt);
            end
        end
    end

    task automatic chk_reset_state(input string nm);
        chk({nm, ".stall"},       32'(stall),       32'd0);
        chk({nm, ".ex_valid"},    32'(ex_valid),    32'd0);
        chk({nm, ".ex_RegWrite"}, 32'(ex_RegWrite), 32'd0);
        chk({nm, ".ex_branch"},   32'(ex_branch),   32'd0);
        chk({nm, ".ex_is_load"},  32'(ex_is_load),  32'd0);
        chk({nm, ".ex_ALUop"},    32'(ex_ALUop),    32'd0);
        chk({nm, ".ex_wreg"},     32'(ex_wreg),     32'd0);
        chk({nm, ".ex_rs_data"},  ex_rs_data,       32'd0);
        chk({nm, ".ex_rt_data"},  ex_rt_data,       32'd0);
        chk({nm, ".ex_imm"},      ex_imm,           32'd0);
        chk({nm, ".ex_pc"},       ex_pc,            32'd0);
        chk({nm, ".stall_cnt"},   32'(stall_cnt),   32'd0);
        chk({nm, ".flush_cnt"},   32'(flush_cnt),   32'd0);
        $display("txn %-10s reset state sampled", nm);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 6'h00, 6'h00, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        chk_reset_state("rst0");
        @(negedge clk);
        rst = 1'b0;

        //     name      v   op     fn     alu   rw    br    rs     rt     rd     fl  | stl valid rw  br  ld   wreg
        issue("add",    1, 6'h03, 6'h20, 3'd0, 1'b1, 1'b0, 5'd1,  5'd2,  5'd5,  1'b0, 0, 1, 1, 0, 0, 5'd5);
        issue("addi",   1, 6'h09, 6'h00, 3'd0, 1'b1, 1'b0, 5'd1,  5'd7,  5'd0,  1'b0, 0, 1, 1, 0, 0, 5'd7);
        issue("lw8",    1, 6'h12, 6'h00, 3'd0, 1'b1, 1'b0, 5'd1,  5'd8,  5'd0,  1'b0, 0, 1, 1, 0, 1, 5'd8);
        issue("sub_st", 1, 6'h03, 6'h22, 3'd1, 1'b1, 1'b0, 5'd8,  5'd3,  5'd9,  1'b0, 1, 0, 0, 0, 0, 5'd0);
        issue("sub",    1, 6'h03, 6'h22, 3'd1, 1'b1, 1'b0, 5'd8,  5'd3,  5'd9,  1'b0, 0, 1, 1, 0, 0, 5'd9);
        issue("lw0",    1, 6'h12, 6'h00, 3'd0, 1'b1, 1'b0, 5'd2,  5'd0,  5'd0,  1'b0, 0, 1, 1, 0, 1, 5'd0);
        issue("use_r0", 1, 6'h03, 6'h20, 3'd0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd4,  1'b0, 0, 1, 1, 0, 0, 5'd4);
        issue("lw8b",   1, 6'h12, 6'h00, 3'd0, 1'b1, 1'b0, 5'd1,  5'd8,  5'd0,  1'b0, 0, 1, 1, 0, 1, 5'd8);
        issue("lui",    1, 6'h0F, 6'h00, 3'd5, 1'b1, 1'b0, 5'd8,  5'd8,  5'd0,  1'b0, 0, 1, 1, 0, 0, 5'd8);
        issue("lw6",    1, 6'h12, 6'h00, 3'd0, 1'b1, 1'b0, 5'd1,  5'd6,  5'd0,  1'b0, 0, 1, 1, 0, 1, 5'd6);
        issue("sw_fl",  1, 6'h2B, 6'h00, 3'd0, 1'b0, 1'b0, 5'd2,  5'd6,  5'd0,  1'b1, 0, 0, 0, 0, 0, 5'd0);
        issue("jal",    1, 6'h07, 6'h00, 3'd0, 1'b1, 1'b0, 5'd6,  5'd0,  5'd0,  1'b0, 0, 1, 1, 0, 0, 5'd31);
        for (int i = 0; i < 5; i++) begin
            issue("flush",  1, 6'h03, 6'h20, 3'd0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 0, 0, 0, 0, 0, 5'd0);
        end
        issue("nop_ld", 0, 6'h12, 6'h00, 3'd0, 1'b1, 1'b1, 5'd1,  5'd8,  5'd0,  1'b0, 0, 0, 0, 0, 0, 5'd0);
        issue("beq",    1, 6'h04, 6'h00, 3'd1, 1'b0, 1'b1, 5'd8,  5'd4,  5'd0,  1'b0, 0, 1, 0, 1, 0, 5'd4);
        issue("lwA",    1, 6'h12, 6'h00, 3'd0, 1'b1, 1'b0, 5'd1,  5'd8,  5'd0,  1'b0, 0, 1, 1, 0, 1, 5'd8);
        issue("lwB_st", 1, 6'h12, 6'h00, 3'd0, 1'b1, 1'b0, 5'd8,  5'd9,  5'd0,  1'b0, 1, 0, 0, 0, 0, 5'd0);
        issue("lwB",    1, 6'h12, 6'h00, 3'd0, 1'b1, 1'b0, 5'd8,  5'd9,  5'd0,  1'b0, 0, 1, 1, 0, 1, 5'd9);
        issue("add9_st",1, 6'h03, 6'h20, 3'd0, 1'b1, 1'b0, 5'd9,  5'd2,  5'd3,  1'b0, 1, 0, 0, 0, 0, 5'd0);
        issue("add9",   1, 6'h03, 6'h20, 3'd0, 1'b1, 1'b0, 5'd9,  5'd2,  5'd3,  1'b0, 0, 1, 1, 0, 0, 5'd3);
        issue("lw5",    1, 6'h12, 6'h00, 3'd0, 1'b1, 1'b0, 5'd1,  5'd5,  5'd0,  1'b0, 0, 1, 1, 0, 1, 5'd5);
        issue("add5_st",1, 6'h03, 6'h20, 3'd0, 1'b1, 1'b0, 5'd5,  5'd2,  5'd3,  1'b0, 1, 0, 0, 0, 0, 5'd0);
        issue("add5",   1, 6'h03, 6'h20, 3'd0, 1'b1, 1'b0, 5'd5,  5'd2,  5'd3,  1'b0, 0, 1, 1, 0, 0, 5'd3);
        issue("lw8c",   1, 6'h12, 6'h00, 3'd0, 1'b1, 1'b0, 5'd1,  5'd8,  5'd0,  1'b0, 0, 1, 1, 0, 1, 5'd8);

        // Reset asserted while a load-use stall is active.
        @(negedge clk);
        drive(1'b1, 6'h03, 6'h22, 3'd1, 1'b1, 1'b0, 5'd8, 5'd3, 5'd9, 1'b0);
        #1;
        chk("pre_rst.stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_state("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        sc_exp = 2'd0;
        fc_exp = 2'd0;
        issue("post_rst", 1, 6'h03, 6'h20, 3'd0, 1'b1, 1'b0, 5'd8, 5'd2, 5'd5, 1'b0, 0, 1, 1, 0, 0, 5'd5);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (stall_q.size() != 0 || ex_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d/%0d left, required 0/0", stall_q.size(), ex_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
